// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared state encoding and width helper for the pattern scan controller
package pattern_scan_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        SHIFT = ST_SHIFT
    } state_t;

    function automatic int len_width(input int pat_max);
        return $clog2(pat_max) + 1;
    endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// rtl/pattern_window_cmp.sv - masked compare of the newest len window bits against the pattern
module pattern_window_cmp
    import pattern_scan_pkg::*;
#(
    parameter int PAT_MAX = 8,
    parameter int LEN_W   = len_width(PAT_MAX)
) (
    input  logic [PAT_MAX-1:0] window,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [PAT_MAX-1:0] mask,
    input  logic [LEN_W-1:0]   len,
    input  logic [LEN_W-1:0]   fill,
    output logic               hit
);

    // A window is only eligible once enough bits have been seen to cover len.
    always_comb begin
        hit = (fill >= len);
        for (int i = 0; i < PAT_MAX; i++) begin
            if ((i < int'(len)) && (window[i] != pattern[i]) && !mask[i]) begin
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-to-bit sequencer feeding a runtime-programmable overlapping pattern detector
// Optional don't-care mask port enabled by defining PAT_MASK_EN.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = len_width(PAT_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
`ifdef PAT_MASK_EN
    input  logic [PAT_MAX-1:0] cfg_mask,
`endif
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy
);

    localparam int IDX_W = $clog2(DATA_W);

    state_t               state, state_nxt;
    logic [DATA_W-1:0]    shifter;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_pend;
    // The oldest bit of a PAT_MAX window is the current bit's predecessor chain, so PAT_MAX-1 bits suffice.
    logic [PAT_MAX-2:0]   hist;
    logic [LEN_W-1:0]     fill;
    logic [PAT_MAX-1:0]   pattern_q;
    logic [LEN_W-1:0]     len_q;
    logic [PAT_MAX-1:0]   mask_q;

    logic [PAT_MAX-1:0]   window;
    logic [LEN_W-1:0]     fill_nxt;
    logic                 hit;
    logic                 cfg_ok;
    logic                 stop_eff;

    assign window   = {hist, shifter[DATA_W-1]};
    assign fill_nxt = (fill == LEN_W'(PAT_MAX)) ? fill : fill + LEN_W'(1);
    assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
    assign stop_eff = stop_pend || stop;

`ifndef PAT_MASK_EN
    assign mask_q = '0;
`endif

    pattern_window_cmp #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .window  (window),
        .pattern (pattern_q),
        .mask    (mask_q),
        .len     (len_q),
        .fill    (fill_nxt),
        .hit     (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop) state_nxt = FETCH;
            FETCH:   if (in_valid) state_nxt = SHIFT;
                     else if (stop) state_nxt = IDLE;
            SHIFT:   if (bit_idx == '0) state_nxt = stop_eff ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == FETCH);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shifter   <= '0;
            bit_idx   <= '0;
            stop_pend <= 1'b0;
            hist      <= '0;
            fill      <= '0;
            pattern_q <= '0;
            len_q     <= LEN_W'(1);
`ifdef PAT_MASK_EN
            mask_q    <= '0;
`endif
            match     <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_load) begin
                if ((state == IDLE) && cfg_ok) begin
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
`ifdef PAT_MASK_EN
                    mask_q    <= cfg_mask;
`endif
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (start && !stop) begin
                        hist      <= '0;
                        fill      <= '0;
                        match_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        shifter   <= in_data;
                        bit_idx   <= IDX_W'(DATA_W - 1);
                        stop_pend <= stop;
                    end
                end
                SHIFT: begin
                    shifter <= {shifter[DATA_W-2:0], 1'b0};
                    bit_idx <= bit_idx - IDX_W'(1);
                    hist    <= window[PAT_MAX-2:0];
                    fill    <= fill_nxt;
                    if (stop) stop_pend <= 1'b1;
                    if (hit) begin
                        match <= 1'b1;
                        if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - scoreboard bench for pattern_scan_ctrl (build with or without PAT_MASK_EN)
module tb_pattern_scan_ctrl;

    localparam int DATA_W  = 8;
    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_load = 1'b0;
    logic [PAT_MAX-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [PAT_MAX-1:0] cfg_mask = '0;
    logic               cfg_err;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data = '0;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;

    pattern_scan_ctrl #(
        .DATA_W  (DATA_W),
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
`ifdef PAT_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic m;
        int   c;
    } exp_t;

    exp_t        exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [7:0]  m_hist, m_pat, m_mask;
    int          m_fill, m_len, m_cnt;
    int          cnt_max = (1 << CNT_W) - 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = '0; m_fill = 0; m_cnt = 0;
        m_pat = '0; m_len = 1; m_mask = '0;
    endtask

    function automatic logic model_bit(input logic b);
        logic [7:0] lenmask;
        m_hist  = {m_hist[6:0], b};
        if (m_fill < PAT_MAX) m_fill++;
        lenmask = 8'((9'd1 << m_len) - 9'd1);
        return (m_fill >= m_len) && (((m_hist ^ m_pat) & ~m_mask & lenmask) == 8'h00);
    endfunction

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] mk);
        logic ok;
        ok = (l >= 1) && (l <= PAT_MAX);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_mask = mk;
        @(posedge clk); @(negedge clk);
        cfg_load = 1'b0;
        check("cfg_err", cfg_err, !ok);
        if (ok) begin
            m_pat = p; m_len = l;
`ifdef PAT_MASK_EN
            m_mask = mk;
`else
            m_mask = '0;
`endif
        end
    endtask

    task automatic start_scan();
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        m_hist = '0; m_fill = 0; m_cnt = 0;
        check("start_ready", in_ready, 1);
        check("start_busy", busy, 1);
        check("start_cnt", match_cnt, 0);
    endtask

    task automatic stop_scan();
        stop = 1'b1;
        @(posedge clk); @(negedge clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_ready", in_ready, 0);
        check("stop_cnt_hold", match_cnt, m_cnt);
    endtask

    // stop_at / cfg_at: bit number (1..8) during whose consuming cycle the input is pulsed, 0 = never
    task automatic send_word(input logic [7:0] w, input int stop_at, input int cfg_at);
        int   guard;
        exp_t e;
        in_valid = 1'b1; in_data = w;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("handshake_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            e.m = model_bit(w[k]);
            if (e.m && m_cnt < cnt_max) m_cnt++;
            e.c = m_cnt;
            exp_q.push_back(e);
        end
        for (int k = 1; k <= DATA_W; k++) begin
            if (k == stop_at) stop = 1'b1;
            if (k == cfg_at) begin
                cfg_load = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd3; cfg_mask = 8'h00;
            end
            @(posedge clk); @(negedge clk);
            stop = 1'b0; cfg_load = 1'b0;
            if (exp_q.size() == 0) begin
                check("sb_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("match_b%0d", k), match, e.m);
                check($sformatf("cnt_b%0d", k), match_cnt, e.c);
            end
            if (k == cfg_at) check("cfg_err_busy", cfg_err, 1);
            if (k < DATA_W) begin
                check("shift_ready", in_ready, 0);
                check("shift_busy", busy, 1);
            end
        end
        if (stop_at != 0) begin
            check("end_idle_busy", busy, 0);
            check("end_idle_ready", in_ready, 0);
        end else begin
            check("end_fetch_ready", in_ready, 1);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, in_ready, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_match"}, match, 0);
        check({pfx, "_cfg_err"}, cfg_err, 0);
        check({pfx, "_cnt"}, match_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // overlap inside one word
        cfg(8'b10110, 4'd5, 8'h00);
        start_scan();
        send_word(8'b1011_0110, 0, 0);
        check("overlap_cnt", match_cnt, 2);
        stop_scan();

        // history carries across a word boundary
        start_scan();
        send_word(8'h05, 0, 0);
        send_word(8'h80, 0, 0);
        check("cross_cnt", match_cnt, 1);
        stop_scan();

        // don't-care bit
        cfg(8'b10110, 4'd5, 8'b00100);
        start_scan();
        send_word(8'b1001_0000, 0, 0);
`ifdef PAT_MASK_EN
        check("mask_cnt", match_cnt, 1);
`else
        check("mask_cnt", match_cnt, 0);
`endif
        stop_scan();

        // rejected configs leave the previous pattern active
        cfg(8'h00, 4'd0, 8'h00);
        cfg(8'h00, 4'd9, 8'h00);
        start_scan();
        send_word(8'b1011_0110, 0, 4);
        check("old_cfg_cnt", match_cnt, 2);
        send_word(8'b1011_0110, 3, 0);

        // start and stop together stay idle
        start = 1'b1; stop = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 0);
        check("startstop_ready", in_ready, 0);

        // full-length pattern only fires once the window is full
        cfg(8'hA5, 4'd8, 8'h00);
        start_scan();
        send_word(8'hA5, 0, 0);
        send_word(8'hA5, 0, 0);
        check("len8_cnt", match_cnt, 2);
        stop_scan();

        // counter saturation
        cfg(8'h01, 4'd1, 8'h00);
        start_scan();
        send_word(8'hFF, 0, 0);
        check("sat_cnt", match_cnt, cnt_max);
        stop_scan();

        // reset in the middle of a word
        start_scan();
        in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
        end
        check("pre_rst_match", match, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        model_reset();
        exp_q.delete();

        // default config after reset is a single 0 bit
        start_scan();
        send_word(8'h00, 0, 0);
        check("rst_cfg_cnt", match_cnt, cnt_max);
        stop_scan();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Controller that feeds a programmable serial pattern detector from a parallel word stream. It accepts words over a valid/ready handshake and serializes them MSB-first into a history register. It detects a runtime-configured pattern of 1..PAT_MAX bits with overlap, and counts matches. It is the sequencing and configuration block in front of the fixed-pattern sequence detectors, replacing one hard-coded FSM per pattern.

## Interface
- DATA_W, 8, input word width (≥2)
- PAT_MAX, 8, maximum pattern length (2..32)
- CNT_W, 16, match counter width
- LEN_W, $clog2(PAT_MAX)+1, derived width of cfg_len
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_load  in  1  latch cfg_pattern/cfg_len (IDLE only)
- cfg_pattern  in  PAT_MAX  pattern; bit len-1 is the oldest bit, bit 0 the newest
- cfg_len  in  LEN_W  pattern length
- cfg_mask  in  PAT_MAX  don't-care mask; present only with PAT_MASK_EN
- cfg_err  out  1  one-cycle pulse when a cfg_load is rejected
- start  in  1  begin scan (IDLE only)
- stop  in  1  request end of scan
- in_valid  in  1  word available
- in_ready  out  1  controller accepts word
- in_data  in  DATA_W  word, MSB shifted first
- match  out  1  one-cycle pulse per detected occurrence
- match_cnt  out  CNT_W  saturating occurrence count
- busy  out  1  high in FETCH and SHIFT

## Operation
- The FSM has 3 states: IDLE, FETCH and SHIFT.
- **IDLE:** in_ready=0, busy=0.
  - On cfg_load, if 1≤cfg_len≤PAT_MAX, latch pattern, len and mask. Otherwise pulse cfg_err and keep the old config.
  - On start, clear hist, fill and match_cnt, then go to FETCH.
  - If start and stop arrive together, stop wins and the FSM stays in IDLE.
- **FETCH:** in_ready=1.
  - On in_valid, load in_data into the word shifter, set bit_idx=DATA_W-1 and go to SHIFT.
  - On stop without in_valid, go to IDLE. If stop and in_valid arrive together, the word is accepted and a stop is made pending.
- **SHIFT:** in_ready=0. Each cycle, one bit b = shifter MSB is consumed.
  - Update: hist ← {hist[PAT_MAX-2:0], b}; fill ← min(fill+1, PAT_MAX).
  - At bit_idx==0, go to IDLE if a stop is pending, else to FETCH.
  - A stop asserted in SHIFT becomes pending. The current word always completes.
- **Match rule:** the comparison is made on the post-update window w = {hist, b}, lowest len bits.
  - A match requires fill+1 ≥ len and, for every i<len, w[i]==pattern[i] or mask[i]=1.
  - Matches overlap, and history carries across word boundaries. History is cleared only by start or rst.
- **Counting:** match_cnt increments on each match and saturates at 2^CNT_W−1. It holds its value in IDLE until the next start.
- **Config writes:** cfg_load outside IDLE is rejected with a cfg_err pulse.
- **Reset values:** IDLE, in_ready=0, busy=0, match=0, cfg_err=0, match_cnt=0, hist=0, fill=0, pattern=0, len=1, mask=0, stop-pending=0.
- **Reset mid-scan:** the current word is discarded and no match pulse is emitted.

## Timing
- All outputs are registered except in_ready and busy, which decode the current state.
- A handshake completes on a clock edge with in_valid&&in_ready.
  - The first bit is consumed at the next edge.
  - The last bit is consumed DATA_W edges after the handshake.
- Throughput is one word per DATA_W+1 cycles when in_valid is held high.
- match goes high in the cycle after the edge that consumed the completing bit. match_cnt updates on that same edge.
- cfg_err goes high in the cycle after a rejected cfg_load.
- After start, FETCH is reached in 1 cycle. After the final bit with a stop pending, IDLE is reached in 1 cycle.

## Configuration
- PAT_MASK_EN defined: the cfg_mask port exists and is latched by cfg_load; bits set to 1 are don't-care.
- PAT_MASK_EN undefined: the cfg_mask port is absent and the internal mask is constant 0, so all len bits are compared.

## Structure
- Shared package pattern_scan_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT);
  - the state encoding localparams (2'b00, 2'b01, 2'b10);
  - the function computing LEN_W.
- Sub-module pattern_window_cmp: combinational masked compare of the window against the pattern over len bits, gated by the fill check. The top level owns the FSM, the shifters and the counter.

## Test plan
- Overlap within a word: pattern 5'b10110, len 5, word 8'b1011_0110 → match pulses after bits 5 and 8; match_cnt=2.
- Cross-word: same pattern, words 8'h05 then 8'h80 → one match, one cycle after B's bit 2 is consumed; match_cnt=1.
- Mask (PAT_MASK_EN): pattern 10110, mask 5'b00100, word 8'b1001_0000 → match after bit 5; match_cnt=1. Without the macro, same stimulus → match_cnt=0.
- Config rejection:
  - cfg_len=0 in IDLE → cfg_err pulse; the old config still matches.
  - cfg_load while busy → cfg_err pulse.
- Stop and start rules:
  - stop asserted at SHIFT bit 3 → remaining 5 bits are consumed, then IDLE; in_ready stays 0 throughout.
  - start+stop together in IDLE → stays IDLE.
- Saturation and reset:
  - CNT_W=2, feed 4 matches → match_cnt holds 3.
  - rst mid-SHIFT → all outputs return to reset values the next cycle.
